// File: rtl/npu_pkg.sv
// Shared dimensions and sequencer state encoding for the 3x3 systolic array job sequencer.
package npu_pkg;
    localparam int N       = 3;
    localparam int DW      = 8;
    localparam int ACCW    = 16;
    localparam int AWIDTH  = 9;
    localparam int ARR_LAT = 3;

    // A token lives from lane-0 entry (age 0) until its row is written (age ARR_LAT+N-1).
    localparam int TOK_DEPTH = ARR_LAT + N;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;
endpackage

// File: rtl/npu_skew.sv
// Per-lane delay line: lane gi is delayed gi stages, or N-1-gi stages when REVERSE is set.
module npu_skew #(
    parameter int N       = 3,
    parameter int W       = 8,
    parameter bit REVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic [N*W-1:0] din,
    output logic [N*W-1:0] dout
);
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int D = REVERSE ? (N - 1 - gi) : gi;
        if (D == 0) begin : g_pass
            assign dout[gi*W +: W] = din[gi*W +: W];
        end else begin : g_dly
            logic [W-1:0] pipe_q [D];
            logic [W-1:0] pipe_d [D];

            always_comb begin
                pipe_d[0] = din[gi*W +: W];
                for (int s = 1; s < D; s++) begin
                    pipe_d[s] = pipe_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (srst || clr) begin
                    for (int s = 0; s < D; s++) begin
                        pipe_q[s] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign dout[gi*W +: W] = pipe_q[D-1];
        end
    end
endmodule

// File: rtl/npu_seq_ctrl.sv
// Job sequencer for the 3x3 weight-stationary systolic array: reads input vectors,
// skews them into the array rows, de-skews the column results and writes each row out.
module npu_seq_ctrl
    import npu_pkg::*;
(
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic                abort,
    input  logic [AWIDTH-1:0]   len,
    input  logic [AWIDTH-1:0]   in_base,
    input  logic [AWIDTH-1:0]   out_base,
    output logic                busy,
    output logic                done,
    output logic                in_rd_en,
    output logic [AWIDTH-1:0]   in_rd_addr,
    input  logic [N*DW-1:0]     in_rd_data,
    output logic [N*DW-1:0]     arr_left,
    output logic                arr_en,
    input  logic [N*ACCW-1:0]   arr_down,
    output logic                out_wr_en,
    output logic [AWIDTH-1:0]   out_wr_addr,
    output logic [N*ACCW-1:0]   out_wr_data
);
    localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

    seq_state_e           state_q, state_d;
    logic [AWIDTH-1:0]    len_q, len_d;
    logic [AWIDTH-1:0]    in_base_q, in_base_d;
    logic [AWIDTH-1:0]    out_base_q, out_base_d;
    logic [AWIDTH:0]      rd_cnt_q, rd_cnt_d;
    logic [AWIDTH:0]      wr_cnt_q, wr_cnt_d;
    logic [TOK_DEPTH-1:0] tok_q, tok_d;
    logic                 last_rd, last_wr, accept;
    logic [N*DW-1:0]      feed_data;
    logic [N*ACCW-1:0]    cap_data;

    assign accept  = (state_q == ST_IDLE) && start && !abort;
    assign last_rd = (rd_cnt_q + CNT_ONE) == {1'b0, len_q};
    assign last_wr = out_wr_en && ((wr_cnt_q + CNT_ONE) == {1'b0, len_q});

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_FEED;
            ST_FEED:  if (last_rd) state_d = ST_DRAIN;
            ST_DRAIN: if (last_wr) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_comb begin
        busy        = (state_q == ST_FEED) || (state_q == ST_DRAIN);
        done        = (state_q == ST_DONE);
        in_rd_en    = (state_q == ST_FEED);
        in_rd_addr  = in_rd_en ? (in_base_q + rd_cnt_q[AWIDTH-1:0]) : '0;
        arr_en      = |tok_q;
        out_wr_en   = tok_q[TOK_DEPTH-1];
        out_wr_addr = out_wr_en ? (out_base_q + wr_cnt_q[AWIDTH-1:0]) : '0;
    end

    always_comb begin
        len_d      = len_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        tok_d      = {tok_q[TOK_DEPTH-2:0], in_rd_en};
        if (accept) begin
            len_d      = len;
            in_base_d  = in_base;
            out_base_d = out_base;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
        end
        if (in_rd_en)  rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (out_wr_en) wr_cnt_d = wr_cnt_q + CNT_ONE;
        // Abort flushes everything in flight so no stale row can be written later.
        if (abort) begin
            tok_d    = '0;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            len_q      <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            tok_q      <= '0;
        end else begin
            len_q      <= len_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            tok_q      <= tok_d;
        end
    end

    // Read data is only meaningful the cycle after a read; elsewhere the lanes carry bubbles.
    assign feed_data = tok_q[0] ? in_rd_data : '0;

    npu_skew #(.N(N), .W(DW), .REVERSE(1'b0)) u_skew (
        .clk  (wb_clk_i),
        .srst (wb_rst_i),
        .clr  (abort),
        .din  (feed_data),
        .dout (arr_left)
    );

    // Column gi of a vector leaves the array when its token reaches age ARR_LAT+gi.
    for (genvar gi = 0; gi < N; gi++) begin : g_cap
        assign cap_data[gi*ACCW +: ACCW] = tok_q[ARR_LAT+gi] ? arr_down[gi*ACCW +: ACCW] : '0;
    end

    npu_skew #(.N(N), .W(ACCW), .REVERSE(1'b1)) u_deskew (
        .clk  (wb_clk_i),
        .srst (wb_rst_i),
        .clr  (abort),
        .din  (cap_data),
        .dout (out_wr_data)
    );
endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Bench for npu_seq_ctrl: input-buffer and 3x3 array models, with a write scoreboard
// fed at job start and drained by an independent monitor.
module tb_npu_seq_ctrl;
    import npu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                start, abort;
    logic [AWIDTH-1:0]   len, in_base, out_base;
    logic                busy, done, in_rd_en, arr_en, out_wr_en;
    logic [AWIDTH-1:0]   in_rd_addr, out_wr_addr;
    logic [N*DW-1:0]     in_rd_data, arr_left;
    logic [N*ACCW-1:0]   arr_down, out_wr_data;

    npu_seq_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
        .len(len), .in_base(in_base), .out_base(out_base),
        .busy(busy), .done(done), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_rd_data(in_rd_data), .arr_left(arr_left), .arr_en(arr_en),
        .arr_down(arr_down), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Input buffer with a registered read port.
    logic [N*DW-1:0] mem [1<<AWIDTH];
    logic [N*DW-1:0] rd_q;
    always @(posedge clk) if (in_rd_en) rd_q <= mem[in_rd_addr];
    assign in_rd_data = rd_q;

    // Weight-stationary array: activations move right, partial sums move down.
    function automatic int w_of(input int r, input int c);
        return r * N + c + 1;
    endfunction

    logic [DW-1:0]   a_q  [N][N];
    logic [ACCW-1:0] p_q  [N][N];
    logic [DW-1:0]   a_in [N][N];
    logic [ACCW-1:0] p_in [N][N];

    always_comb begin
        a_in = '{default: '0};
        p_in = '{default: '0};
        for (int r = 0; r < N; r++) begin
            a_in[r][0] = arr_left[r*DW +: DW];
            for (int c = 1; c < N; c++) a_in[r][c] = a_q[r][c-1];
        end
        for (int c = 0; c < N; c++) begin
            for (int r = 1; r < N; r++) p_in[r][c] = p_q[r-1][c];
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (rst) begin
                    a_q[r][c] <= '0;
                    p_q[r][c] <= '0;
                end else if (arr_en) begin
                    a_q[r][c] <= a_in[r][c];
                    p_q[r][c] <= p_in[r][c] + ACCW'(a_in[r][c]) * ACCW'(w_of(r, c));
                end
            end
        end
    end

    always_comb begin
        arr_down = '0;
        for (int c = 0; c < N; c++) arr_down[c*ACCW +: ACCW] = p_q[N-1][c];
    end

    // Reference: y[j] = sum_i x[i] * W[i][j], truncated to ACCW bits.
    function automatic logic [N*ACCW-1:0] ref_row(input logic [N*DW-1:0] x);
        logic [N*ACCW-1:0] y;
        logic [ACCW-1:0]   s;
        y = '0;
        for (int j = 0; j < N; j++) begin
            s = '0;
            for (int i = 0; i < N; i++) s = s + ACCW'(x[i*DW +: DW]) * ACCW'(w_of(i, j));
            y[j*ACCW +: ACCW] = s;
        end
        return y;
    endfunction

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [N*ACCW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    int rd_exp, rd_n, wr_n, done_n, en_n, first_rd, first_wr, last_wr, done_cyc;
    logic busy_at_done;
    int lane_cyc [N];
    int lane_val [N];

    task automatic clear_mon();
        rd_n = 0; wr_n = 0; done_n = 0; en_n = 0;
        first_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
        busy_at_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            lane_cyc[i] = -1;
            lane_val[i] = -1;
        end
    endtask

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge and drains the scoreboard on every write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (in_rd_en) begin
                    n_vec++;
                    if (in_rd_addr !== AWIDTH'(rd_exp)) begin
                        n_bad++;
                        $display("FAIL rd_addr: got %h, required %h", in_rd_addr, AWIDTH'(rd_exp));
                    end
                    if (rd_n == 0) first_rd = cyc;
                    rd_n++;
                    rd_exp++;
                end
                for (int i = 0; i < N; i++) begin
                    if (lane_cyc[i] < 0 && arr_left[i*DW +: DW] != '0) begin
                        lane_cyc[i] = cyc;
                        lane_val[i] = int'(arr_left[i*DW +: DW]);
                    end
                end
                if (arr_en) en_n++;
                if (out_wr_en) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL wr_unexpected: got addr %h data %h, required no write",
                                 out_wr_addr, out_wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_wr_addr !== e.addr || out_wr_data !== e.data) begin
                            n_bad++;
                            $display("FAIL wr_row: got addr %h data %h, required addr %h data %h",
                                     out_wr_addr, out_wr_data, e.addr, e.data);
                        end else begin
                            $display("wr  cyc=%0d addr=%h data=%h", cyc, out_wr_addr, out_wr_data);
                        end
                    end
                    if (wr_n == 0) first_wr = cyc;
                    last_wr = cyc;
                    wr_n++;
                end
                if (done) begin
                    done_n++;
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
            end
        end
    end

    task automatic push_rows(input int l, input int ib, input int ob);
        wr_t e;
        for (int k = 0; k < l; k++) begin
            e.addr = AWIDTH'(ob + k);
            e.data = ref_row(mem[AWIDTH'(ib + k)]);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_job(input int l, input int ib, input int ob);
        @(negedge clk);
        clear_mon();
        rd_exp   = ib;
        len      = AWIDTH'(l);
        in_base  = AWIDTH'(ib);
        out_base = AWIDTH'(ob);
        start    = 1'b1;
        t0       = cyc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int i = 0;
        while (done_n == 0 && i < limit) begin
            @(posedge clk);
            #1;
            i++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({name, "_done_n"}, done_n, 1);
    endtask

    task automatic job_checks(input string name, input int l);
        check({name, "_rd_n"}, rd_n, l);
        check({name, "_wr_n"}, wr_n, l);
        check({name, "_wr_span"}, last_wr - first_wr, l - 1);
        check({name, "_done_cyc"}, done_cyc - t0, l + 7);
        check({name, "_busy_at_done"}, busy_at_done, 0);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        $display("job %s len=%0d t0=%0d done@+%0d", name, l, t0, done_cyc - t0);
    endtask

    initial begin
        wr_t e;
        logic quiet;
        int l, ib, ob;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        len = '0; in_base = '0; out_base = '0;
        rd_exp = 0;
        clear_mon();
        for (int a = 0; a < (1 << AWIDTH); a++) mem[a] = (N*DW)'($urandom);
        mem[0] = {8'd3, 8'd2, 8'd1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", in_rd_en, 0);
        check("rst_arr_en", arr_en, 0);
        check("rst_wr_en", out_wr_en, 0);
        check("rst_arr_left", arr_left, 0);
        check("rst_wr_data", out_wr_data, 0);
        check("rst_addrs", {in_rd_addr, out_wr_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: single vector {3,2,1}; W = [[1,2,3],[4,5,6],[7,8,9]] gives row (30,36,42).
        e.addr = 9'h010;
        e.data = {16'd42, 16'd36, 16'd30};
        exp_q.push_back(e);
        start_job(1, 0, 'h010);
        wait_done("t1", 40);
        check("t1_first_rd", first_rd - t0, 1);
        check("t1_lane0_cyc", lane_cyc[0] - t0, 2);
        check("t1_lane0_val", lane_val[0], 1);
        check("t1_lane1_cyc", lane_cyc[1] - t0, 3);
        check("t1_lane1_val", lane_val[1], 2);
        check("t1_lane2_cyc", lane_cyc[2] - t0, 4);
        check("t1_lane2_val", lane_val[2], 3);
        check("t1_first_wr", first_wr - t0, 7);
        job_checks("t1", 1);

        // 2: address wrap on both buffers.
        push_rows(4, 'h1FE, 'h1FF);
        start_job(4, 'h1FE, 'h1FF);
        wait_done("t2", 40);
        check("t2_first_rd", first_rd - t0, 1);
        job_checks("t2", 4);

        // 3: zero-length job.
        start_job(0, 5, 7);
        wait_done("t3", 20);
        check("t3_done_cyc", done_cyc - t0, 1);
        check("t3_rd_n", rd_n, 0);
        check("t3_wr_n", wr_n, 0);
        check("t3_en_n", en_n, 0);

        // 4: second start while busy is ignored.
        push_rows(5, 'h020, 'h040);
        start_job(5, 'h020, 'h040);
        @(negedge clk);
        len = 9; in_base = 'h100; out_base = 'h180; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", 60);
        repeat (15) @(posedge clk);
        #1;
        check("t4_single_done", done_n, 1);
        job_checks("t4", 5);

        // 5: abort on the third FEED cycle, then a clean len=2 job.
        start_job(6, 'h030, 'h060);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy_after_abort", busy, 0);
        quiet = arr_en | in_rd_en | out_wr_en | done | busy;
        repeat (15) begin
            @(negedge clk);
            quiet = quiet | arr_en | in_rd_en | out_wr_en | done | busy;
        end
        @(posedge clk);
        #1;
        check("t5_quiet", quiet, 0);
        check("t5_rd_n", rd_n, 3);
        check("t5_wr_n", wr_n, 0);
        check("t5_done_n", done_n, 0);
        push_rows(2, 'h070, 'h071);
        start_job(2, 'h070, 'h071);
        wait_done("t5b", 40);
        job_checks("t5b", 2);

        // 6: random lengths and bases against the matrix-product reference.
        for (int j = 0; j < 6; j++) begin
            l  = int'($urandom_range(1, 20));
            ib = int'($urandom_range(0, (1 << AWIDTH) - 1));
            ob = int'($urandom_range(0, (1 << AWIDTH) - 1));
            push_rows(l, ib, ob);
            start_job(l, ib, ob);
            wait_done("t6", l + 40);
            job_checks("t6", l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1000000, required finish");
        $fatal(1, "watchdog");
    end
endmodule
